// File: rtl/fill_scheduler.sv
// Purpose : round-robin arbiter that serialises per-source fill requests onto one fill stream.
// Latency : fill_valid / reject appear 1 cycle after the src_valid & src_ready handshake.
// Backpress: src_ready is held low during ISSUE and GAP, so fills are spaced GAP_CYCLES apart.
//
// Ports
//   clk, rstn        clock (rising edge) and asynchronous active-low reset
//   enable           permits new grants; an issue/gap sequence in progress always completes
//   src_valid/ready  per-source request / one-hot (or zero) accept strobe, combinational
//   src_qty/price    packed 32-bit fields, source i in bits [32i+31:32i]
//   src_side         packed 8-bit sides, 1=Buy 2=Sell
//   fill_*           registered fill towards the position tracker, fill_valid is a 1-cycle pulse
//   fill_src         index of the source behind the current fill or reject
//   reject           1-cycle pulse for an accepted but malformed request (bad side or qty=0)
//   busy             high whenever the FSM is not in IDLE
//   Optional (FILL_SCHED_STATS_EN defined): grant_total, reject_total, stall_cycles counters.
module fill_scheduler #(
    parameter int NUM_SRC    = 4,
    parameter int GAP_CYCLES = 5
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   enable,
    input  logic [NUM_SRC-1:0]     src_valid,
    output logic [NUM_SRC-1:0]     src_ready,
    input  logic [NUM_SRC*32-1:0]  src_qty,
    input  logic [NUM_SRC*32-1:0]  src_price,
    input  logic [NUM_SRC*8-1:0]   src_side,
    output logic                   fill_valid,
    output logic [31:0]            fill_qty,
    output logic [31:0]            fill_price,
    output logic [7:0]             fill_side,
    output logic [2:0]             fill_src,
    output logic                   reject,
    output logic                   busy
`ifdef FILL_SCHED_STATS_EN
    ,
    output logic [31:0]            grant_total,
    output logic [31:0]            reject_total,
    output logic [31:0]            stall_cycles
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    // GAP lasts GAP_CYCLES-2 cycles; the counter runs from GAP_INIT down to 0.
    localparam logic [3:0] GAP_INIT = (GAP_CYCLES > 2) ? 4'(GAP_CYCLES - 3) : 4'd0;

    logic [1:0]  state_q, state_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic [2:0]  last_grant_q, last_grant_d;
    logic        fill_valid_q, fill_valid_d;
    logic        reject_q, reject_d;
    logic [31:0] fill_qty_q, fill_qty_d;
    logic [31:0] fill_price_q, fill_price_d;
    logic [7:0]  fill_side_q, fill_side_d;
    logic [2:0]  fill_src_q, fill_src_d;

    // Arbitration results
    logic        grant_any;
    logic        grant_ok;
    logic [2:0]  grant_idx;
    logic [31:0] sel_qty;
    logic [31:0] sel_price;
    logic [7:0]  sel_side;
    logic        well_formed;
    logic        xfer;
    int          arb_dist;
    int          arb_best;

    // Round-robin pick: each source gets a distance from last_grant+1; the
    // valid source with the smallest distance wins. Only valid sources are
    // considered, so a source that drops its request never moves the pointer.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = 3'd0;
        sel_qty   = 32'd0;
        sel_price = 32'd0;
        sel_side  = 8'd0;
        arb_dist  = 0;
        arb_best  = NUM_SRC;
        for (int i = 0; i < NUM_SRC; i++) begin
            arb_dist = (i + 2 * NUM_SRC - int'(last_grant_q) - 1) % NUM_SRC;
            if (src_valid[i] && (arb_dist < arb_best)) begin
                arb_best  = arb_dist;
                grant_any = 1'b1;
                grant_idx = 3'(i);
                sel_qty   = src_qty[32*i +: 32];
                sel_price = src_price[32*i +: 32];
                sel_side  = src_side[8*i +: 8];
            end
        end
    end

    // Ready is gated with rstn so every output reads zero while reset is held.
    assign grant_ok = rstn && (state_q == IDLE) && enable && grant_any;

    always_comb begin
        src_ready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_ready[i] = grant_ok && (grant_idx == 3'(i));
        end
    end

    assign xfer        = |(src_valid & src_ready);
    assign well_formed = (sel_qty != 32'd0) && ((sel_side == 8'd1) || (sel_side == 8'd2));

    always_comb begin
        state_d      = state_q;
        gap_cnt_d    = gap_cnt_q;
        last_grant_d = last_grant_q;
        fill_valid_d = 1'b0;
        reject_d     = 1'b0;
        fill_qty_d   = fill_qty_q;
        fill_price_d = fill_price_q;
        fill_side_d  = fill_side_q;
        fill_src_d   = fill_src_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    last_grant_d = grant_idx;
                    fill_src_d   = grant_idx;
                    if (well_formed) begin
                        // Fill payload only changes on a real fill, so it
                        // keeps the last issued fill across rejects.
                        fill_qty_d   = sel_qty;
                        fill_price_d = sel_price;
                        fill_side_d  = sel_side;
                        fill_valid_d = 1'b1;
                        state_d      = ISSUE;
                    end else begin
                        // Malformed: consumed and reported, FSM stays in IDLE
                        // so the next source can be granted immediately.
                        reject_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (GAP_CYCLES == 2) begin
                    state_d = IDLE;
                end else begin
                    state_d   = GAP;
                    gap_cnt_d = GAP_INIT;
                end
            end
            GAP: begin
                if (gap_cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d   = IDLE;
                gap_cnt_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            gap_cnt_q    <= 4'd0;
            last_grant_q <= 3'(NUM_SRC - 1);
            fill_valid_q <= 1'b0;
            reject_q     <= 1'b0;
            fill_qty_q   <= 32'd0;
            fill_price_q <= 32'd0;
            fill_side_q  <= 8'd0;
            fill_src_q   <= 3'd0;
        end else begin
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            last_grant_q <= last_grant_d;
            fill_valid_q <= fill_valid_d;
            reject_q     <= reject_d;
            fill_qty_q   <= fill_qty_d;
            fill_price_q <= fill_price_d;
            fill_side_q  <= fill_side_d;
            fill_src_q   <= fill_src_d;
        end
    end

    assign fill_valid = fill_valid_q;
    assign fill_qty   = fill_qty_q;
    assign fill_price = fill_price_q;
    assign fill_side  = fill_side_q;
    assign fill_src   = fill_src_q;
    assign reject     = reject_q;
    assign busy       = (state_q != IDLE);

`ifdef FILL_SCHED_STATS_EN
    logic [31:0] grant_total_q, grant_total_d;
    logic [31:0] reject_total_q, reject_total_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;

    // Counters wrap naturally at 2^32.
    always_comb begin
        grant_total_d  = grant_total_q + 32'(fill_valid_q);
        reject_total_d = reject_total_q + 32'(reject_q);
        stall_cycles_d = stall_cycles_q + 32'((|src_valid) && (src_ready == '0));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            grant_total_q  <= 32'd0;
            reject_total_q <= 32'd0;
            stall_cycles_q <= 32'd0;
        end else begin
            grant_total_q  <= grant_total_d;
            reject_total_q <= reject_total_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign grant_total  = grant_total_q;
    assign reject_total = reject_total_q;
    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_fill_scheduler.sv
// Purpose : self-checking bench for fill_scheduler with a timing-based reference model.
// Latency : model expects fill/reject one cycle after each predicted grant.
// Backpress: model forbids grants until GAP_CYCLES after a good grant.
module tb_fill_scheduler;
    localparam int N   = 4;
    localparam int GAP = 5;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             enable = 1'b0;
    logic [N-1:0]     src_valid = '0;
    logic [N-1:0]     src_ready;
    logic [N*32-1:0]  src_qty = '0;
    logic [N*32-1:0]  src_price = '0;
    logic [N*8-1:0]   src_side = '0;
    logic             fill_valid;
    logic [31:0]      fill_qty;
    logic [31:0]      fill_price;
    logic [7:0]       fill_side;
    logic [2:0]       fill_src;
    logic             reject;
    logic             busy;
`ifdef FILL_SCHED_STATS_EN
    logic [31:0]      grant_total;
    logic [31:0]      reject_total;
    logic [31:0]      stall_cycles;
`endif

    fill_scheduler #(.NUM_SRC(N), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rstn(rstn), .enable(enable),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_qty(src_qty), .src_price(src_price), .src_side(src_side),
        .fill_valid(fill_valid), .fill_qty(fill_qty), .fill_price(fill_price),
        .fill_side(fill_side), .fill_src(fill_src), .reject(reject), .busy(busy)
`ifdef FILL_SCHED_STATS_EN
        , .grant_total(grant_total), .reject_total(reject_total), .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Time based: a grant is allowed at cycle c when enabled and c >= m_free.
    // A good grant frees the port GAP cycles later; a reject frees it next cycle.
    int          m_last;
    int          m_free;
    int          m_busy_end;
    bit          m_exp_fv;
    bit          m_exp_rej;
    logic [31:0] m_qty;
    logic [31:0] m_price;
    logic [7:0]  m_side;
    int          m_src;
    int          m_grants;
    int          m_rejects;
    int          m_stall;
    logic [N-1:0] e_ready;
    int          e_g;

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (!rstn) begin
            check("rst_src_ready", src_ready, 0);
            check("rst_fill_valid", fill_valid, 0);
            check("rst_fill_qty", fill_qty, 0);
            check("rst_fill_price", fill_price, 0);
            check("rst_fill_side", fill_side, 0);
            check("rst_fill_src", fill_src, 0);
            check("rst_reject", reject, 0);
            check("rst_busy", busy, 0);
`ifdef FILL_SCHED_STATS_EN
            check("rst_grant_total", grant_total, 0);
            check("rst_reject_total", reject_total, 0);
            check("rst_stall_cycles", stall_cycles, 0);
`endif
            m_last = N - 1; m_free = 0; m_busy_end = 0;
            m_exp_fv = 0; m_exp_rej = 0;
            m_grants = 0; m_rejects = 0; m_stall = 0;
        end else begin
            check("fill_valid", fill_valid, m_exp_fv);
            if (m_exp_fv) begin
                check("fill_qty", fill_qty, m_qty);
                check("fill_price", fill_price, m_price);
                check("fill_side", fill_side, m_side);
                check("fill_src", fill_src, m_src);
                m_grants++;
            end
            check("reject", reject, m_exp_rej);
            if (m_exp_rej) begin
                check("reject_src", fill_src, m_src);
                m_rejects++;
            end
            check("busy", busy, cyc < m_busy_end);

            e_ready = '0;
            e_g = -1;
            if (enable && cyc >= m_free) begin
                e_g = rr_pick(src_valid, m_last);
                if (e_g >= 0) e_ready[e_g] = 1'b1;
            end
            check("src_ready", src_ready, e_ready);
            if ((|src_valid) && e_ready == '0) m_stall++;

            m_exp_fv = 0;
            m_exp_rej = 0;
            if (e_g >= 0) begin
                m_src = e_g;
                m_last = e_g;
                if (src_qty[32*e_g +: 32] != 0 &&
                    (src_side[8*e_g +: 8] == 8'd1 || src_side[8*e_g +: 8] == 8'd2)) begin
                    m_qty   = src_qty[32*e_g +: 32];
                    m_price = src_price[32*e_g +: 32];
                    m_side  = src_side[8*e_g +: 8];
                    m_exp_fv = 1;
                    m_free = cyc + GAP;
                    m_busy_end = cyc + GAP;
                end else begin
                    m_exp_rej = 1;
                    m_free = cyc + 1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic v, input logic [31:0] q,
                           input logic [31:0] p, input logic [7:0] s);
        src_valid[i]         = v;
        src_qty[32*i +: 32]  = q;
        src_price[32*i +: 32] = p;
        src_side[8*i +: 8]   = s;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (3) tick();
        src_valid = '0;
        rstn = 1'b1;
    endtask

    int grant_order[$];
    int fill_times[$];

    initial begin
        enable = 1'b1;
        // Requests held during reset must not be acknowledged.
        for (int i = 0; i < N; i++) set_src(i, 1'b1, 32'd1 + 32'(i), 32'd9, 8'd1);
        repeat (3) tick();
        src_valid = '0;
        rstn = 1'b1;
        tick();

        // First transfer: ready in cycle t, fill in t+1.
        set_src(0, 1'b1, 32'd100, 32'd5000, 8'd1);
        @(negedge clk);
        check("first_ready", src_ready, 4'b0001);
        tick();
        src_valid = '0;
        @(negedge clk);
        check("first_fill_valid", fill_valid, 1);
        check("first_fill_qty", fill_qty, 100);
        check("first_fill_price", fill_price, 5000);
        check("first_fill_side", fill_side, 1);
        check("first_fill_src", fill_src, 0);
        repeat (6) tick();

        // All sources continuously valid: order and spacing.
        do_reset();
        for (int i = 0; i < N; i++) set_src(i, 1'b1, 32'd10 + 32'(i), 32'd200 + 32'(i), 8'd2);
        repeat (30) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) if (src_ready[i]) grant_order.push_back(i);
            if (fill_valid) fill_times.push_back(cyc);
            tick();
        end
        src_valid = '0;
        check("rr_count_ok", (grant_order.size() >= 5 && fill_times.size() >= 5), 1);
        if (grant_order.size() >= 5 && fill_times.size() >= 5) begin
            check("rr_order0", grant_order[0], 0);
            check("rr_order1", grant_order[1], 1);
            check("rr_order2", grant_order[2], 2);
            check("rr_order3", grant_order[3], 3);
            check("rr_order4", grant_order[4], 0);
            for (int k = 1; k < 5; k++) check("rr_spacing", fill_times[k] - fill_times[k-1], GAP);
        end
        repeat (6) tick();

        // Malformed side on source 2, then source 3 granted next cycle.
        do_reset();
        set_src(2, 1'b1, 32'd7, 32'd70, 8'd3);
        set_src(3, 1'b1, 32'd8, 32'd80, 8'd2);
        @(negedge clk);
        check("rej_ready2", src_ready, 4'b0100);
        tick();
        @(negedge clk);
        check("rej_pulse", reject, 1);
        check("rej_src", fill_src, 2);
        check("rej_no_fill", fill_valid, 0);
        check("rej_next_ready3", src_ready, 4'b1000);
        tick();
        src_valid = '0;
        repeat (6) tick();

        // enable dropped after handshake: fill still issues, no grants until re-enabled.
        set_src(0, 1'b1, 32'd55, 32'd66, 8'd2);
        @(negedge clk);
        check("en_ready0", src_ready, 4'b0001);
        tick();
        enable = 1'b0;
        set_src(1, 1'b1, 32'd77, 32'd88, 8'd1);
        @(negedge clk);
        check("en_fill_valid", fill_valid, 1);
        repeat (8) begin
            tick();
            @(negedge clk);
            check("en_off_no_ready", src_ready, 0);
        end
        check("en_gap_done", busy, 0);
        tick();
        enable = 1'b1;
        @(negedge clk);
        check("en_back_ready1", src_ready, 4'b0010);
        tick();
        src_valid = '0;
        repeat (6) tick();

        // Reset in the middle of GAP with requests pending.
        set_src(1, 1'b1, 32'd11, 32'd12, 8'd1);
        set_src(2, 1'b1, 32'd21, 32'd22, 8'd2);
        @(negedge clk);
        check("mid_ready2", src_ready, 4'b0100);
        tick();
        tick();
        rstn = 1'b0;
        #1;
        check("mid_rst_ready", src_ready, 0);
        check("mid_rst_fill_valid", fill_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_qty", fill_qty, 0);
        tick();
        tick();
        rstn = 1'b1;
        @(negedge clk);
        check("mid_rel_ready1", src_ready, 4'b0010);
        check("mid_rel_no_fill", fill_valid, 0);
        tick();
        src_valid = '0;
        repeat (6) tick();

`ifdef FILL_SCHED_STATS_EN
        // Three good fills and one reject.
        do_reset();
        for (int i = 0; i < 3; i++) set_src(i, 1'b1, 32'd5, 32'd6, 8'd1);
        set_src(3, 1'b1, 32'd5, 32'd6, 8'd0);
        repeat (16) tick();
        src_valid = '0;
        repeat (3) tick();
        check("stats_grant_total", grant_total, 3);
        check("stats_reject_total", reject_total, 1);
`endif

        // Randomized traffic.
        for (int it = 0; it < 400; it++) begin
            if (it == 200) begin
                rstn = 1'b0;
                tick();
                tick();
                rstn = 1'b1;
            end
            enable = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < N; i++) begin
                set_src(i, ($urandom_range(0, 9) < 6),
                        ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom),
                        32'($urandom), 8'($urandom_range(0, 3)));
            end
            tick();
        end
        src_valid = '0;
        @(negedge clk);
        tick();
`ifdef FILL_SCHED_STATS_EN
        check("end_grant_total", grant_total, m_grants);
        check("end_reject_total", reject_total, m_rejects);
        check("end_stall_cycles", stall_cycles, m_stall);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
